// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, bubble word, opcode field and
// opcode values, and the fetch FSM state encoding.
package pipeline_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  localparam logic [5:0] OP_OR   = 6'h00;
  localparam logic [5:0] OP_AND  = 6'h01;
  localparam logic [5:0] OP_ADD  = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_NOT  = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h07;
  localparam logic [5:0] OP_LW   = 6'h08;
  localparam logic [5:0] OP_SW   = 6'h09;
  localparam logic [5:0] OP_BZ   = 6'h0A;
  localparam logic [5:0] OP_BGZ  = 6'h0B;
  localparam logic [5:0] OP_BLZ  = 6'h0C;
  localparam logic [5:0] OP_JR   = 6'h0D;
  localparam logic [5:0] OP_JUMP = 6'h0E;
  localparam logic [5:0] OP_CALL = 6'h0F;

  // Fetch FSM encoding
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: redirect priority mux (JR > JUMP/CALL > branch) and
// sequential increment. Purely combinational; redirects only count when
// the instruction in decode is valid.
module next_pc_sel #(
  parameter int ADDR_W = pipeline_pkg::PC_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              ifid_valid,
  input  logic              call_f,
  input  logic              jump_f,
  input  logic              jr_f,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jr_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] pc_next
);
  import pipeline_pkg::*;

  assign pc_inc   = pc + ADDR_W'(1);
  assign redirect = ifid_valid & (jr_f | jump_f | call_f | branch_taken);

  // First matching redirect source wins; otherwise fall through to pc+1
  always_comb begin
    pc_next = pc_inc;
    if (ifid_valid) begin
      if (jr_f)                  pc_next = jr_target;
      else if (jump_f || call_f) pc_next = jump_target;
      else if (branch_taken)     pc_next = branch_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives instruction memory, and holds the IF/ID
// pipeline register. Applies decode's stall and redirects, and latches a
// permanent halt on turn_off.
// Optional: define FETCH_STATS_EN to add saturating fetch/stall/flush counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// BOOT    | first cycle after reset; fetch pc with no bubble
// RUN     | normal fetch; stall > turn_off > redirect > sequential
// HALT    | fetch stopped, IF/ID held at bubble until reset
module fetch_stage #(
  parameter int                PC_W      = pipeline_pkg::PC_W,
  parameter int                INSTR_W   = pipeline_pkg::INSTR_W,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               call_f,
  input  logic               jump_f,
  input  logic               jr_f,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    jr_target,
  input  logic               turn_off,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_next,
  output logic               ifid_valid,
  output logic               halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_stalls,
  output logic [31:0]        stat_flushes
`endif
);
  import pipeline_pkg::*;

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic            redirect;
  logic            halt_req;

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);
  // turn_off only counts when the instruction carrying it is real
  assign halt_req  = turn_off & ifid_valid;

  next_pc_sel #(.ADDR_W(PC_W)) u_next_pc_sel (
    .pc            (pc),
    .ifid_valid    (ifid_valid),
    .call_f        (call_f),
    .jump_f        (jump_f),
    .jr_f          (jr_f),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .jr_target     (jr_target),
    .redirect      (redirect),
    .pc_inc        (pc_inc),
    .pc_next       (pc_next)
  );

  // FSM, PC and IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_BOOT;
      pc           <= RESET_PC;
      ifid_instr   <= NOP_INSTR;
      ifid_pc      <= '0;
      ifid_pc_next <= '0;
      ifid_valid   <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          pc           <= pc_inc;
          ifid_instr   <= imem_data;
          ifid_pc      <= pc;
          ifid_pc_next <= pc_inc;
          ifid_valid   <= 1'b1;
          state        <= ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            // hold everything
          end else if (halt_req || redirect) begin
            // halt keeps pc; a redirect in the same cycle is dropped
            if (!halt_req) pc <= pc_next;
            else           state <= ST_HALT;
            ifid_instr   <= NOP_INSTR;
            ifid_pc      <= '0;
            ifid_pc_next <= '0;
            ifid_valid   <= 1'b0;
          end else begin
            pc           <= pc_next;
            ifid_instr   <= imem_data;
            ifid_pc      <= pc;
            ifid_pc_next <= pc_inc;
            ifid_valid   <= 1'b1;
          end
        end
        ST_HALT: begin
          // frozen until reset
        end
        default: state <= ST_HALT;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic fetch_load;
  logic stall_cyc;
  logic flush_cyc;

  assign fetch_load = (state == ST_BOOT) ||
                      ((state == ST_RUN) && !stall && !halt_req && !redirect);
  assign stall_cyc  = (state == ST_RUN) && stall;
  assign flush_cyc  = (state == ST_RUN) && !stall && !halt_req && redirect;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Saturating event counters; nothing qualifies in HALT, so they freeze there
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_stalls  <= '0;
      stat_flushes <= '0;
    end else begin
      if (fetch_load) stat_fetched <= sat_inc(stat_fetched);
      if (stall_cyc)  stat_stalls  <= sat_inc(stat_stalls);
      if (flush_cyc)  stat_flushes <= sat_inc(stat_flushes);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Instruction memory returns ~addr so
// every fetched word identifies its own address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr, imem_data;
  logic        stall = 0, call_f = 0, jump_f = 0, jr_f = 0, branch_taken = 0, turn_off = 0;
  logic [31:0] jump_target = 0, branch_target = 0, jr_target = 0;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_next;
  logic        ifid_valid, halted;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_stalls, stat_flushes;
`endif

  always #5 clk = ~clk;
  assign imem_data = ~imem_addr;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .call_f(call_f), .jump_f(jump_f), .jr_f(jr_f),
    .branch_taken(branch_taken), .jump_target(jump_target),
    .branch_target(branch_target), .jr_target(jr_target), .turn_off(turn_off),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_next(ifid_pc_next),
    .ifid_valid(ifid_valid), .halted(halted)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_stalls(stat_stalls), .stat_flushes(stat_flushes)
`endif
  );

  // flags: {rst, stall, jump, call, jr, branch, turn_off}
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] RST  = 7'b1000000;
  localparam logic [6:0] STL  = 7'b0100000;
  localparam logic [6:0] JMP  = 7'b0010000;
  localparam logic [6:0] CAL  = 7'b0001000;
  localparam logic [6:0] JRF  = 7'b0000100;
  localparam logic [6:0] BRF  = 7'b0000010;
  localparam logic [6:0] OFF  = 7'b0000001;

  // one cycle of stimulus plus the outputs expected after the next edge
  typedef struct packed {
    logic [6:0]  flags;
    logic [31:0] jt, brt, jrt;
    logic [31:0] addr, pc;
    logic        valid, halted;
  } row_t;

  row_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic row_t mk(input logic [6:0] f, input logic [31:0] jt, brt, jrt,
                              input logic [31:0] addr, pc, input logic v, h);
    row_t r;
    r.flags = f; r.jt = jt; r.brt = brt; r.jrt = jrt;
    r.addr = addr; r.pc = pc; r.valid = v; r.halted = h;
    return r;
  endfunction

  // drive one row's inputs and queue its expectation
  task automatic apply(input row_t r);
    reset         = r.flags[6];
    stall         = r.flags[5];
    jump_f        = r.flags[4];
    call_f        = r.flags[3];
    jr_f          = r.flags[2];
    branch_taken  = r.flags[1];
    turn_off      = r.flags[0];
    jump_target   = r.jt;
    branch_target = r.brt;
    jr_target     = r.jrt;
    sb.push_back(r);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, 32'h0); end
    total++; if (ifid_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=%h", ifid_instr, 32'h0); end
    total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", ifid_pc, 32'h0); end
    total++; if (ifid_pc_next !== 32'h0) begin bad++; $display("FAIL reset_pcn got=%h want=%h", ifid_pc_next, 32'h0); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ifid_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    row_t rs[$];
    rs.push_back(mk(IDLE, 0, 0, 0, 32'd1, 32'd0, 1, 0));
    rs.push_back(mk(IDLE, 0, 0, 0, 32'd2, 32'd1, 1, 0));
    rs.push_back(mk(IDLE, 0, 0, 0, 32'd3, 32'd2, 1, 0));
    rs.push_back(mk(IDLE, 0, 0, 0, 32'd4, 32'd3, 1, 0));
    foreach (rs[i]) begin
      row_t e; logic [31:0] ei, epn;
      apply(rs[i]); @(posedge clk); #1;
      e = sb.pop_front();
      ei = e.valid ? ~e.pc : 32'h0; epn = e.valid ? e.pc + 32'd1 : 32'd0;
      total++;
      if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted} !== {e.addr, ei, e.pc, epn, e.valid, e.halted}) begin
        bad++;
        $display("FAIL seq step %0d: got addr=%h instr=%h pc=%h pcn=%h v=%b h=%b want addr=%h instr=%h pc=%h pcn=%h v=%b h=%b",
                 i, imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted, e.addr, ei, e.pc, epn, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_jump();
    row_t rs[$];
    rs.push_back(mk(JMP,  32'h40, 0, 0, 32'h40, 32'h0,  0, 0));
    rs.push_back(mk(IDLE, 0,      0, 0, 32'h41, 32'h40, 1, 0));
    rs.push_back(mk(IDLE, 0,      0, 0, 32'h42, 32'h41, 1, 0));
    foreach (rs[i]) begin
      row_t e; logic [31:0] ei, epn;
      apply(rs[i]); @(posedge clk); #1;
      e = sb.pop_front();
      ei = e.valid ? ~e.pc : 32'h0; epn = e.valid ? e.pc + 32'd1 : 32'd0;
      total++;
      if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted} !== {e.addr, ei, e.pc, epn, e.valid, e.halted}) begin
        bad++;
        $display("FAIL jump step %0d: got addr=%h instr=%h pc=%h pcn=%h v=%b h=%b want addr=%h instr=%h pc=%h pcn=%h v=%b h=%b",
                 i, imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted, e.addr, ei, e.pc, epn, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_stall();
    row_t rs[$];
    rs.push_back(mk(JMP,       32'h4,  0, 0, 32'h4, 32'h0, 0, 0));
    rs.push_back(mk(IDLE,      0,      0, 0, 32'h5, 32'h4, 1, 0));
    rs.push_back(mk(IDLE,      0,      0, 0, 32'h6, 32'h5, 1, 0));
    rs.push_back(mk(STL,       0,      0, 0, 32'h6, 32'h5, 1, 0));
    rs.push_back(mk(STL,       0,      0, 0, 32'h6, 32'h5, 1, 0));
    rs.push_back(mk(IDLE,      0,      0, 0, 32'h7, 32'h6, 1, 0));
    rs.push_back(mk(STL | JMP, 32'h80, 0, 0, 32'h7, 32'h6, 1, 0));
    rs.push_back(mk(IDLE,      0,      0, 0, 32'h8, 32'h7, 1, 0));
    foreach (rs[i]) begin
      row_t e; logic [31:0] ei, epn;
      apply(rs[i]); @(posedge clk); #1;
      e = sb.pop_front();
      ei = e.valid ? ~e.pc : 32'h0; epn = e.valid ? e.pc + 32'd1 : 32'd0;
      total++;
      if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted} !== {e.addr, ei, e.pc, epn, e.valid, e.halted}) begin
        bad++;
        $display("FAIL stall step %0d: got addr=%h instr=%h pc=%h pcn=%h v=%b h=%b want addr=%h instr=%h pc=%h pcn=%h v=%b h=%b",
                 i, imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted, e.addr, ei, e.pc, epn, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_priority();
    row_t rs[$];
    rs.push_back(mk(JRF | BRF,       0,      32'h20, 32'h10, 32'h10, 32'h0,  0, 0));
    rs.push_back(mk(JRF | BRF,       0,      32'h20, 32'h10, 32'h11, 32'h10, 1, 0));
    rs.push_back(mk(JMP | CAL | BRF, 32'h30, 32'h50, 0,      32'h30, 32'h0,  0, 0));
    rs.push_back(mk(CAL | BRF,       32'h60, 32'h70, 0,      32'h31, 32'h30, 1, 0));
    rs.push_back(mk(BRF,             0,      32'h20, 0,      32'h20, 32'h0,  0, 0));
    rs.push_back(mk(IDLE,            0,      0,      0,      32'h21, 32'h20, 1, 0));
    rs.push_back(mk(CAL,             32'h90, 0,      0,      32'h90, 32'h0,  0, 0));
    rs.push_back(mk(IDLE,            0,      0,      0,      32'h91, 32'h90, 1, 0));
    foreach (rs[i]) begin
      row_t e; logic [31:0] ei, epn;
      apply(rs[i]); @(posedge clk); #1;
      e = sb.pop_front();
      ei = e.valid ? ~e.pc : 32'h0; epn = e.valid ? e.pc + 32'd1 : 32'd0;
      total++;
      if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted} !== {e.addr, ei, e.pc, epn, e.valid, e.halted}) begin
        bad++;
        $display("FAIL prio step %0d: got addr=%h instr=%h pc=%h pcn=%h v=%b h=%b want addr=%h instr=%h pc=%h pcn=%h v=%b h=%b",
                 i, imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted, e.addr, ei, e.pc, epn, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rs[$];
    rs.push_back(mk(JMP,  32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 32'h0,         0, 0));
    rs.push_back(mk(IDLE, 0,             0, 0, 32'h0,         32'hFFFF_FFFF, 1, 0));
    rs.push_back(mk(IDLE, 0,             0, 0, 32'h1,         32'h0,         1, 0));
    foreach (rs[i]) begin
      row_t e; logic [31:0] ei, epn;
      apply(rs[i]); @(posedge clk); #1;
      e = sb.pop_front();
      ei = e.valid ? ~e.pc : 32'h0; epn = e.valid ? e.pc + 32'd1 : 32'd0;
      total++;
      if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted} !== {e.addr, ei, e.pc, epn, e.valid, e.halted}) begin
        bad++;
        $display("FAIL wrap step %0d: got addr=%h instr=%h pc=%h pcn=%h v=%b h=%b want addr=%h instr=%h pc=%h pcn=%h v=%b h=%b",
                 i, imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted, e.addr, ei, e.pc, epn, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_halt();
    row_t rs[$];
    rs.push_back(mk(JMP,       32'h100, 0,      0,      32'h100, 32'h0,   0, 0));
    rs.push_back(mk(OFF,       0,       0,      0,      32'h101, 32'h100, 1, 0));
    rs.push_back(mk(OFF | STL, 0,       0,      0,      32'h101, 32'h100, 1, 0));
    rs.push_back(mk(OFF | JMP, 32'h200, 0,      0,      32'h101, 32'h0,   0, 1));
    rs.push_back(mk(JMP,       32'h300, 0,      0,      32'h101, 32'h0,   0, 1));
    rs.push_back(mk(BRF | JRF, 0,       32'h44, 32'h55, 32'h101, 32'h0,   0, 1));
    rs.push_back(mk(STL,       0,       0,      0,      32'h101, 32'h0,   0, 1));
    rs.push_back(mk(IDLE,      0,       0,      0,      32'h101, 32'h0,   0, 1));
    rs.push_back(mk(RST,       0,       0,      0,      32'h0,   32'h0,   0, 0));
    rs.push_back(mk(IDLE,      0,       0,      0,      32'h1,   32'h0,   1, 0));
    rs.push_back(mk(IDLE,      0,       0,      0,      32'h2,   32'h1,   1, 0));
    rs.push_back(mk(STL,       0,       0,      0,      32'h2,   32'h1,   1, 0));
    rs.push_back(mk(RST | STL, 0,       0,      0,      32'h0,   32'h0,   0, 0));
    rs.push_back(mk(IDLE,      0,       0,      0,      32'h1,   32'h0,   1, 0));
    foreach (rs[i]) begin
      row_t e; logic [31:0] ei, epn;
      apply(rs[i]); @(posedge clk); #1;
      e = sb.pop_front();
      ei = e.valid ? ~e.pc : 32'h0; epn = e.valid ? e.pc + 32'd1 : 32'd0;
      total++;
      if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted} !== {e.addr, ei, e.pc, epn, e.valid, e.halted}) begin
        bad++;
        $display("FAIL halt step %0d: got addr=%h instr=%h pc=%h pcn=%h v=%b h=%b want addr=%h instr=%h pc=%h pcn=%h v=%b h=%b",
                 i, imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted, e.addr, ei, e.pc, epn, e.valid, e.halted);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_stall();
    test_priority();
    test_wrap();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
